// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and pc step.
`ifndef WORD
`define WORD 32
`endif

package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_skid.sv
// Single-entry {pc, instr} buffer that parks a response while decode is stalled.
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int WIDTH = `WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_instr,
    output logic             valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr
);

    // Capture on load, drop the entry on clear; clear wins if both are seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= in_pc;
            instr <= in_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, skid buffer, decode register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = `WORD,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               IMEM_POWER = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stallD,
    input  logic                  flushD,
    input  logic                  redirect_valid,
    input  logic [WIDTH-1:0]      redirect_pc,
    output logic                  imem_req_valid,
    output logic [IMEM_POWER-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [WIDTH-1:0]      imem_rsp_data,
    output logic                  validD,
    output logic [WIDTH-1:0]      pcD,
    output logic [WIDTH-1:0]      instrD
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] pc, pc_next;
    logic [WIDTH-1:0] req_pc, req_pc_next;
    logic             drop, drop_next;

    logic             load_dec;
    logic [WIDTH-1:0] dec_pc_in;
    logic [WIDTH-1:0] dec_instr_in;

    logic             skid_load;
    logic             skid_clear;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_pc;
    logic [WIDTH-1:0] skid_instr;

    logic [WIDTH-1:0] redirect_target;
    logic             dec_free;
    logic             unused_bits;

    assign redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};
    assign dec_free        = !validD || !stallD;
    assign imem_req_valid  = (state == REQ) && !reset;
    assign imem_req_addr   = pc[IMEM_POWER+1:2];
    assign unused_bits     = ^{redirect_pc[1:0], pc};

    fetch_skid #(.WIDTH(WIDTH)) skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .in_pc    (req_pc),
        .in_instr (imem_rsp_data),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    // State register together with fetch pc, in-flight request pc and drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
            drop   <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
            drop   <= drop_next;
        end
    end

    // Next-state logic: redirect beats everything, stale responses are discarded.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        req_pc_next  = req_pc;
        drop_next    = drop;
        load_dec     = 1'b0;
        dec_pc_in    = skid_pc;
        dec_instr_in = skid_instr;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        case (state)
            REQ: begin
                if (imem_req_ready) begin
                    state_next  = WAIT;
                    req_pc_next = pc;
                    drop_next   = redirect_valid;
                end
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_next = 1'b0;
                    if (drop || redirect_valid) begin
                        state_next = REQ;
                    end else if (dec_free) begin
                        load_dec     = 1'b1;
                        dec_pc_in    = req_pc;
                        dec_instr_in = imem_rsp_data;
                        pc_next      = req_pc + STEP;
                        state_next   = REQ;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    skid_clear = 1'b1;
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (!stallD) begin
                    load_dec   = skid_valid;
                    skid_clear = 1'b1;
                    pc_next    = skid_pc + STEP;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // Decode register: flush clears, a load fills, an unstalled decode consumes.
    always_ff @(posedge clk) begin
        if (reset || flushD) begin
            validD <= 1'b0;
            pcD    <= '0;
            instrD <= '0;
        end else if (load_dec) begin
            validD <= 1'b1;
            pcD    <= dec_pc_in;
            instrD <= dec_instr_in;
        end else if (!stallD) begin
            validD <= 1'b0;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter WIDTH, default `WORD: instruction and address width in bits.
REQ-002 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-003 Parameter IMEM_POWER, default 18: word-address bits presented to instruction memory.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 stallD  in  1  decode cannot accept; hold decode outputs.
REQ-007 flushD  in  1  squash the decode-register contents.
REQ-008 redirect_valid  in  1  branch/jump taken; refetch from redirect_pc.
REQ-009 redirect_pc  in  WIDTH  redirect target; bits [1:0] ignored.
REQ-010 imem_req_valid  out  1  fetch request valid.
REQ-011 imem_req_addr  out  IMEM_POWER  word address (pc >> 2).
REQ-012 imem_req_ready  in  1  memory accepts request this cycle.
REQ-013 imem_rsp_valid  in  1  instruction returned this cycle.
REQ-014 imem_rsp_data  in  WIDTH  returned instruction.
REQ-015 validD  out  1  decode register holds a live instruction.
REQ-016 pcD  out  WIDTH  pc of instruction in decode register.
REQ-017 instrD  out  WIDTH  instruction in decode register.

Function
REQ-018 FSM states: REQ (drive request), WAIT (one request outstanding), HOLD (response buffered, decode stalled); at most one outstanding request.
REQ-019 REQ: imem_req_valid=1, addr=pc[IMEM_POWER+1:2]; on imem_req_ready -> WAIT, latch pc as req_pc.
REQ-020 WAIT: on imem_rsp_valid with drop=0 and decode register free (validD=0 or stallD=0) -> load {req_pc, data} into decode register, validD=1, pc<=req_pc+4, -> REQ.
REQ-021 WAIT: on imem_rsp_valid with decode register blocked (validD=1 and stallD=1) -> capture into skid buffer, -> HOLD; no new request.
REQ-022 HOLD: when stallD=0, move buffer into decode register, pc<=buffered pc+4, -> REQ.
REQ-023 stallD=1 with validD=1: pcD, instrD, validD unchanged.
REQ-024 flushD=1: validD<=0 next cycle, pcD/instrD<=0; overrides stallD; REQ-020/022 loads in the same cycle are squashed (pc still advances).
REQ-025 redirect_valid (priority over all): pc<={redirect_pc[WIDTH-1:2],2'b00}; skid buffer discarded; REQ/HOLD -> REQ next cycle.
REQ-026 Redirect in WAIT without same-cycle response: set drop=1, stay WAIT; response arriving with drop=1 is discarded, drop<=0, -> REQ.
REQ-027 Redirect in the same cycle as imem_rsp_valid: response discarded, -> REQ with target.
REQ-028 Redirect in REQ with imem_req_ready same cycle: request counted as outstanding with drop=1.
REQ-029 pc arithmetic modulo 2^WIDTH; wrap from all-ones word to 0 is legal.
REQ-030 Minimum latency: request accepted cycle N, response cycle N+1 -> validD=1 from N+2; sustained throughput one instruction per two cycles.

Reset
REQ-031 reset: state=REQ, pc=RESET_PC, drop=0, skid empty, validD=0, pcD=0, instrD=0.
REQ-032 reset mid-transaction: any later response to a pre-reset request carries no identification, so memory shall be reset with the same signal; fetch_stage discards nothing extra.
REQ-033 imem_req_valid=0 during the reset cycle, 1 on first cycle after reset release.

Structure
REQ-034 Shared package fetch_pkg: state enum (REQ, WAIT, HOLD) and PC_STEP=4 constant.
REQ-035 One sub-module fetch_skid: single-entry {pc, instr} buffer with load/clear/valid.

Verification
REQ-036 Reset release, RESET_PC=0x100, ready=1, 1-cycle latency, data 0xA,0xB -> pcD/instrD = 0x100/0xA then 0x104/0xB, validD pulses every other cycle.
REQ-037 stallD held 4 cycles while response 0xC arrives -> HOLD, no request, pcD/instrD unchanged; stallD=0 -> 0xC loaded next cycle.
REQ-038 Redirect to 0x203 during WAIT -> stale response discarded, next imem_req_addr=0x80 (pc 0x200).
REQ-039 Redirect coincident with response -> response never reaches decode; next request at target.
REQ-040 flushD with stallD=1, validD=1 -> validD=0, pcD=instrD=0 next cycle.
REQ-041 pc=0xFFFFFFFC response -> pcD=0xFFFFFFFC, next request pc 0x0.
